// File: rtl/alu_exec_pipe_if.sv
// Shared packages and the issue/writeback bus for alu_exec_pipe.
// The packages live here so they are compiled ahead of both the
// interface and the execution pipe that import them.

package parameters;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

package common;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_cmd_t;
endpackage

// One issue port and one writeback port per dispatch bank.
interface alu_exec_pipe_if;
  logic [parameters::DISPATCH_WIDTH-1:0]                                       issue_valid;
  common::alu_cmd_t [parameters::DISPATCH_WIDTH-1:0]                           issue_alu_cmd;
  logic [parameters::DISPATCH_WIDTH-1:0][31:0]                                 issue_op1;
  logic [parameters::DISPATCH_WIDTH-1:0][31:0]                                 issue_op2;
  logic [parameters::DISPATCH_WIDTH-1:0][parameters::PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd;
  logic [parameters::DISPATCH_WIDTH-1:0]                                       wb_valid;
  logic [parameters::DISPATCH_WIDTH-1:0][parameters::PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd;
  logic [parameters::DISPATCH_WIDTH-1:0][31:0]                                 wb_data;

  // Issue side: drives ops, observes writeback.
  modport master (
    output issue_valid, issue_alu_cmd, issue_op1, issue_op2, issue_phys_rd,
    input  wb_valid, wb_phys_rd, wb_data
  );

  // Execution side: consumes ops, produces writeback.
  modport slave (
    input  issue_valid, issue_alu_cmd, issue_op1, issue_op2, issue_phys_rd,
    output wb_valid, wb_phys_rd, wb_data
  );
endinterface

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: per-bank integer ALU with a fixed ALU_LATENCY (1..3)
// register pipeline from issue to writeback. Never stalls; flush kills
// everything in flight plus anything issued in the flush cycle.
// Optional feature: define EXEC_PERF_CNT_EN to build the completed-op
// counter on exec_count; otherwise exec_count is tied to 0.

module alu_exec_pipe
  import parameters::*;
  import common::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_exec_pipe_if.slave       bus,
  output logic [31:0]          exec_count
);

  // Result is formed at issue; the pipeline only carries it. Any command
  // encoding outside the defined set falls back to ADD.
  function automatic logic [31:0] alu_result(input alu_cmd_t cmd,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case (cmd)
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'b0, (a < b)};
      default:  r = a + b;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_bank
    logic [31:0]                                       result;
    logic [ALU_LATENCY-1:0]                            valid_reg;
    logic [ALU_LATENCY-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  tag_reg;
    logic [ALU_LATENCY-1:0][31:0]                      data_reg;

    assign result = alu_result(bus.issue_alu_cmd[gi], bus.issue_op1[gi], bus.issue_op2[gi]);

    // Shift valid/tag/data through the stages. Tag and data are forced to
    // zero alongside a cleared valid so the writeback port reads 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= '0;
        tag_reg   <= '0;
        data_reg  <= '0;
      end else if (flush) begin
        valid_reg <= '0;
        tag_reg   <= '0;
        data_reg  <= '0;
      end else begin
        valid_reg[0] <= bus.issue_valid[gi];
        tag_reg[0]   <= bus.issue_valid[gi] ? bus.issue_phys_rd[gi] : '0;
        data_reg[0]  <= bus.issue_valid[gi] ? result : '0;
        for (int s = 1; s < ALU_LATENCY; s++) begin
          valid_reg[s] <= valid_reg[s-1];
          tag_reg[s]   <= tag_reg[s-1];
          data_reg[s]  <= data_reg[s-1];
        end
      end
    end

    assign bus.wb_valid[gi]   = valid_reg[ALU_LATENCY-1];
    assign bus.wb_phys_rd[gi] = tag_reg[ALU_LATENCY-1];
    assign bus.wb_data[gi]    = data_reg[ALU_LATENCY-1];
  end

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] exec_count_reg;
  logic [31:0] done_count;

  // Number of banks completing an op this cycle.
  always_comb begin
    done_count = '0;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      done_count = done_count + 32'(bus.wb_valid[b]);
    end
  end

  // Running total of completed ops; wraps naturally at 2^32. Flushed ops
  // never reach wb_valid, so they are never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_count_reg <= '0;
    end else begin
      exec_count_reg <= exec_count_reg + done_count;
    end
  end

  assign exec_count = exec_count_reg;
`else
  assign exec_count = '0;
`endif

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed self-checking bench for alu_exec_pipe: three instances at
// ALU_LATENCY 1, 2 and 3 share clock and reset.
module tb_alu_exec_pipe;
  import parameters::*;
  import common::*;

`ifdef EXEC_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush1, flush2, flush3;
  logic [31:0] exec_count1, exec_count2, exec_count3;
  int          checks;
  int          errors;
  int          cyc;

  alu_exec_pipe_if bus1();
  alu_exec_pipe_if bus2();
  alu_exec_pipe_if bus3();

  alu_exec_pipe #(.ALU_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(bus1), .exec_count(exec_count1));
  alu_exec_pipe #(.ALU_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .flush(flush2), .bus(bus2), .exec_count(exec_count2));
  alu_exec_pipe #(.ALU_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .flush(flush3), .bus(bus3), .exec_count(exec_count3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Directed ALU vectors: command, operands, hand-computed result.
  logic [3:0]  vec_cmd [13] = '{4'd7, 4'd8, 4'd9, 4'd1, 4'd0, 4'd2, 4'd3,
                                4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'hC};
  logic [31:0] vec_a   [13] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                                32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000,
                                32'h1, 32'h80000000, 32'h1, 32'h1, 32'h3};
  logic [31:0] vec_b   [13] = '{32'h4, 32'h1, 32'h1, 32'h1,
                                32'h2, 32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0F0F,
                                32'h23, 32'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4};
  logic [31:0] vec_e   [13] = '{32'hF8000000, 32'h1, 32'h0, 32'hFFFFFFFF,
                                32'h1, 32'hF000F000, 32'hFFFFF0F0, 32'hF0F00F0F,
                                32'h8, 32'h1, 32'h0, 32'h1, 32'h7};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_all();
    bus1.issue_valid = '0; bus2.issue_valid = '0; bus3.issue_valid = '0;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      bus1.issue_alu_cmd[b] = ALU_ADD; bus1.issue_op1[b] = '0; bus1.issue_op2[b] = '0; bus1.issue_phys_rd[b] = '0;
      bus2.issue_alu_cmd[b] = ALU_ADD; bus2.issue_op1[b] = '0; bus2.issue_op2[b] = '0; bus2.issue_phys_rd[b] = '0;
      bus3.issue_alu_cmd[b] = ALU_ADD; bus3.issue_op1[b] = '0; bus3.issue_op2[b] = '0; bus3.issue_phys_rd[b] = '0;
    end
  endtask

  initial begin
    int j;
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; flush1 = 1'b0; flush2 = 1'b0; flush3 = 1'b0;
    idle_all();

    // Reset state
    #12;
    check("rst lat1 wb_valid", 32'(bus1.wb_valid), 32'd0);
    check("rst lat1 wb_data0", bus1.wb_data[0], 32'd0);
    check("rst lat2 wb_valid", 32'(bus2.wb_valid), 32'd0);
    check("rst lat3 wb_phys_rd0", 32'(bus3.wb_phys_rd[0]), 32'd0);
    check("rst exec_count1", exec_count1, 32'd0);

    // First cycle with rst low accepts an issue
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    bus1.issue_valid[0] = 1'b1; bus1.issue_alu_cmd[0] = ALU_SUB;
    bus1.issue_op1[0] = 32'd9; bus1.issue_op2[0] = 32'd4; bus1.issue_phys_rd[0] = 6'd7;
    $display("issue cyc=%0d lat1 b0 SUB 9-4 rd=7", cyc);
    tick();
    check("first lat1 wb_valid", 32'(bus1.wb_valid), 32'd1);
    check("first lat1 rd0", 32'(bus1.wb_phys_rd[0]), 32'd7);
    check("first lat1 data0", bus1.wb_data[0], 32'd5);
    idle_all();

    // ADD 5+7 at cycle 10, writeback at cycle 11
    while (cyc < 10) tick();
    bus1.issue_valid[0] = 1'b1; bus1.issue_alu_cmd[0] = ALU_ADD;
    bus1.issue_op1[0] = 32'd5; bus1.issue_op2[0] = 32'd7; bus1.issue_phys_rd[0] = 6'd3;
    $display("issue cyc=%0d lat1 b0 ADD 5+7 rd=3", cyc);
    tick();
    idle_all();
    check("cyc11 wb_valid", 32'(bus1.wb_valid), 32'd1);
    check("cyc11 rd0", 32'(bus1.wb_phys_rd[0]), 32'd3);
    check("cyc11 data0", bus1.wb_data[0], 32'd12);

    // ALU operation vectors, both banks every cycle
    for (int i = 0; i < 13; i++) begin
      int k;
      k = (i + 5) % 13;
      bus1.issue_valid = '1;
      bus1.issue_alu_cmd[0] = alu_cmd_t'(vec_cmd[i]); bus1.issue_op1[0] = vec_a[i];
      bus1.issue_op2[0] = vec_b[i]; bus1.issue_phys_rd[0] = 6'(i);
      bus1.issue_alu_cmd[1] = alu_cmd_t'(vec_cmd[k]); bus1.issue_op1[1] = vec_a[k];
      bus1.issue_op2[1] = vec_b[k]; bus1.issue_phys_rd[1] = 6'(i + 32);
      $display("vec %0d: b0 cmd=%0d a=%08h b=%08h | b1 cmd=%0d a=%08h b=%08h",
               i, vec_cmd[i], vec_a[i], vec_b[i], vec_cmd[k], vec_a[k], vec_b[k]);
      tick();
      check($sformatf("vec%0d valid", i), 32'(bus1.wb_valid), 32'd3);
      check($sformatf("vec%0d b0 data", i), bus1.wb_data[0], vec_e[i]);
      check($sformatf("vec%0d b1 data", i), bus1.wb_data[1], vec_e[k]);
      check($sformatf("vec%0d b1 rd", i), 32'(bus1.wb_phys_rd[1]), 32'(i + 32));
    end
    idle_all();
    tick();
    check("idle valid", 32'(bus1.wb_valid), 32'd0);
    check("idle data0", bus1.wb_data[0], 32'd0);
    check("idle rd1", 32'(bus1.wb_phys_rd[1]), 32'd0);

    // Completed-op counter: all banks valid for 4 cycles on lat3
    for (int i = 0; i < 4; i++) begin
      bus3.issue_valid = '1;
      for (int b = 0; b < DISPATCH_WIDTH; b++) begin
        bus3.issue_alu_cmd[b] = ALU_ADD; bus3.issue_op1[b] = 32'd1; bus3.issue_op2[b] = 32'd1;
        bus3.issue_phys_rd[b] = 6'd1;
      end
      $display("count issue %0d lat3 all banks", i);
      tick();
    end
    idle_all();
    for (int i = 0; i < 3; i++) tick();
    check("exec_count3 after 4", exec_count3, PERF_EN ? 32'(4 * DISPATCH_WIDTH) : 32'd0);
    tick();
    check("exec_count3 stable", exec_count3, PERF_EN ? 32'(4 * DISPATCH_WIDTH) : 32'd0);

    // lat3 stream: 20 cycles, all banks; bank0 reuses one tag
    for (int i = 0; i < 23; i++) begin
      if (i < 20) begin
        bus3.issue_valid = '1;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
          bus3.issue_alu_cmd[b] = ALU_ADD;
          bus3.issue_op1[b] = 32'(i);
          bus3.issue_op2[b] = 32'(1000 * (b + 1));
          bus3.issue_phys_rd[b] = (b == 0) ? 6'd5 : 6'(i + 10);
        end
        $display("stream issue %0d lat3", i);
      end else begin
        idle_all();
      end
      tick();
      j = i - 2;
      for (int b = 0; b < DISPATCH_WIDTH; b++) begin
        if (j >= 0 && j < 20) begin
          check($sformatf("stream i%0d b%0d valid", i, b), 32'(bus3.wb_valid[b]), 32'd1);
          check($sformatf("stream i%0d b%0d rd", i, b), 32'(bus3.wb_phys_rd[b]),
                (b == 0) ? 32'd5 : 32'(j + 10));
          check($sformatf("stream i%0d b%0d data", i, b), bus3.wb_data[b],
                32'(j + 1000 * (b + 1)));
        end else begin
          check($sformatf("stream i%0d b%0d idle", i, b), 32'(bus3.wb_valid[b]), 32'd0);
        end
      end
    end
    check("exec_count3 after stream", exec_count3,
          PERF_EN ? 32'(24 * DISPATCH_WIDTH) : 32'd0);

    // Flush on lat2: ops at cycles 5,6, flush in 6, new op in 7
    bus2.issue_valid = '1;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      bus2.issue_alu_cmd[b] = ALU_ADD; bus2.issue_op1[b] = 32'd1; bus2.issue_op2[b] = 32'd1;
      bus2.issue_phys_rd[b] = 6'd1;
    end
    $display("flush test: issue A lat2");
    tick();
    flush2 = 1'b1;
    $display("flush test: issue B with flush lat2");
    tick();
    flush2 = 1'b0;
    idle_all();
    bus2.issue_valid[0] = 1'b1; bus2.issue_alu_cmd[0] = ALU_ADD;
    bus2.issue_op1[0] = 32'd10; bus2.issue_op2[0] = 32'd20; bus2.issue_phys_rd[0] = 6'd9;
    $display("flush test: issue C lat2 ADD 10+20 rd=9");
    check("flush c7 valid", 32'(bus2.wb_valid), 32'd0);
    check("flush c7 data0", bus2.wb_data[0], 32'd0);
    check("flush c7 rd0", 32'(bus2.wb_phys_rd[0]), 32'd0);
    tick();
    idle_all();
    check("flush c8 valid", 32'(bus2.wb_valid), 32'd0);
    tick();
    check("flush c9 valid", 32'(bus2.wb_valid), 32'd1);
    check("flush c9 rd0", 32'(bus2.wb_phys_rd[0]), 32'd9);
    check("flush c9 data0", bus2.wb_data[0], 32'd30);
    tick();
    check("flush c10 valid", 32'(bus2.wb_valid), 32'd0);
    check("exec_count2 after flush", exec_count2, PERF_EN ? 32'd1 : 32'd0);

    // Asynchronous reset between edges
    bus1.issue_valid = '1;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      bus1.issue_alu_cmd[b] = ALU_ADD; bus1.issue_op1[b] = 32'd2; bus1.issue_op2[b] = 32'd3;
      bus1.issue_phys_rd[b] = 6'd4;
    end
    $display("async rst: issue lat1 ADD 2+3 rd=4");
    tick();
    idle_all();
    check("pre-rst valid", 32'(bus1.wb_valid), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(bus1.wb_valid), 32'd0);
    check("async rst data0", bus1.wb_data[0], 32'd0);
    check("async rst rd1", 32'(bus1.wb_phys_rd[1]), 32'd0);
    check("async rst exec_count1", exec_count1, 32'd0);
    check("async rst exec_count3", exec_count3, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("post-rst valid", 32'(bus1.wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1, meaning cycles from issue to writeback, legal range 1..3.
REQ-002 SHALL take DISPATCH_WIDTH, PHYS_REGS_ADDR_WIDTH and common::alu_cmd_t from the parameters and common packages.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  kill all in-flight ops.
REQ-006 SHALL have port issue_valid  input  1 x DISPATCH_WIDTH  op present in bank.
REQ-007 SHALL have port issue_alu_cmd  input  alu_cmd_t x DISPATCH_WIDTH  operation.
REQ-008 SHALL have ports issue_op1, issue_op2  input  32 x DISPATCH_WIDTH  resolved operands.
REQ-009 SHALL have port issue_phys_rd  input  PHYS_REGS_ADDR_WIDTH x DISPATCH_WIDTH  destination tag.
REQ-010 SHALL have port wb_valid  output  1 x DISPATCH_WIDTH  result valid, feeds issue queue wakeup.
REQ-011 SHALL have port wb_phys_rd  output  PHYS_REGS_ADDR_WIDTH x DISPATCH_WIDTH  result tag.
REQ-012 SHALL have port wb_data  output  32 x DISPATCH_WIDTH  result value.
REQ-013 SHALL have port exec_count  output  32  completed-op counter (see Configuration).

Function
REQ-014 SHALL process each bank independently; bank b issue maps only to bank b writeback.
REQ-015 SHALL compute: ADD op1+op2, SUB op1-op2, AND, OR, XOR, SLL op1<<op2[4:0], SRL logical, SRA arithmetic, SLT signed (1/0), SLTU unsigned (1/0); all modulo 2^32.
REQ-016 SHALL compute result combinationally at issue, then carry valid/tag/data through ALU_LATENCY register stages; issue in cycle N appears on wb outputs in cycle N+ALU_LATENCY.
REQ-017 SHALL accept one op per bank every cycle with no backpressure; pipeline never stalls.
REQ-018 SHALL output wb_phys_rd and wb_data as 0 whenever the corresponding wb_valid is 0.
REQ-019 SHALL, on flush sampled high, clear every stage valid bit at that edge; ops issued in the same cycle as flush are discarded; wb_valid is 0 for the next ALU_LATENCY cycles unless new ops issue after flush.
REQ-020 SHALL treat unknown/unsupported alu_cmd values as ADD.
REQ-021 SHALL produce wb for back-to-back ops to the same phys_rd in issue order, one per cycle.

Reset
REQ-022 SHALL, on rst high, asynchronously clear all stage valid, tag and data registers to 0, so wb_valid=0, wb_phys_rd=0, wb_data=0 immediately.
REQ-023 SHALL clear exec_count to 0 on rst; ops in flight at reset assertion are lost.
REQ-024 SHALL accept issue in the first cycle rst is low.

Configuration
REQ-025 SHALL, with macro EXEC_PERF_CNT_EN defined, increment exec_count each cycle by the number of banks with wb_valid=1, wrapping at 2^32; flushed ops not counted.
REQ-026 SHALL, without EXEC_PERF_CNT_EN, tie exec_count to 0 and instantiate no counter.

Verification
REQ-027 Bench SHALL check: ALU_LATENCY=1, bank0 ADD 5+7 rd=3 at cycle 10 -> cycle 11 wb_valid[0]=1, wb_phys_rd[0]=3, wb_data[0]=12.
REQ-028 Bench SHALL check: SRA 0x80000000 by 4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0; SUB 0-1 -> 0xFFFFFFFF.
REQ-029 Bench SHALL check: ALU_LATENCY=3, ops every cycle on all banks for 20 cycles -> 20 consecutive wb per bank starting 3 cycles later, order and tags preserved.
REQ-030 Bench SHALL check: ALU_LATENCY=2, ops issued cycles 5,6, flush at cycle 6 -> no wb_valid in cycles 7-8; op issued cycle 7 writes back cycle 9.
REQ-031 Bench SHALL check: rst asserted mid-stream between clock edges -> wb_valid drops to 0 before next edge; exec_count=0.
REQ-032 Bench SHALL check: EXEC_PERF_CNT_EN defined, DISPATCH_WIDTH banks all valid 4 cycles -> exec_count=4*DISPATCH_WIDTH; undefined -> exec_count stays 0.
